timer_setter: RTL and testbench

Front-end control block for the egg timer: turns four debounced push-buttons into an MM:SS preset and drives the load/start side of the countdown counter. It holds the user-entered BCD digits, walks an edit → run → pause → alarm state machine, and consumes the counter's done flag to raise the alarm. It sits between the button debouncers and the countdown counter; its digit outputs feed the counter's preset inputs directly.

---
 rtl/timer_pkg.sv | 33 +++
 rtl/timer_setter_if.sv | 28 ++
 rtl/timer_setter_button_edge.sv | 17 +
 rtl/timer_setter.sv | 118 +++++++++++
 tb/tb_timer_setter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared types, digit limits and sel encoding for the egg-timer setter.
// digit_step() does one BCD up/down step with wrap at a per-digit maximum.
package timer_pkg;

    typedef enum logic [1:0] {
        EDIT  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam logic [3:0] SEC_ONES_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_ONES_MAX = 4'd9;

    localparam logic [1:0] SEL_A1 = 2'd0;
    localparam logic [1:0] SEL_B1 = 2'd1;
    localparam logic [1:0] SEL_C1 = 2'd2;
    localparam logic [1:0] SEL_D1 = 2'd3;

    // Compare-to-limit wrap; never relies on 4-bit overflow.
    function automatic logic [3:0] digit_step(
        input logic [3:0] d,
        input logic [3:0] lim,
        input logic       up
    );
        if (up)
            return (d >= lim) ? 4'd0 : d + 4'd1;
        else
            return (d == 4'd0) ? lim : d - 4'd1;
    endfunction

endpackage

// File: rtl/timer_setter_if.sv
// Button/done inputs and preset/control outputs of the timer setter.
// master: button side + counter feedback; slave: the timer_setter itself.
interface timer_setter_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_sel;
    logic       btn_start;
    logic       dn;
    logic [3:0] a1;
    logic [3:0] b1;
    logic [3:0] c1;
    logic [3:0] d1;
    logic       load;
    logic       str;
    logic       clr;
    logic [1:0] sel;
    logic       alarm;

    modport master (
        output btn_up, btn_down, btn_sel, btn_start, dn,
        input  a1, b1, c1, d1, load, str, clr, sel, alarm
    );

    modport slave (
        input  btn_up, btn_down, btn_sel, btn_start, dn,
        output a1, b1, c1, d1, load, str, clr, sel, alarm
    );
endinterface

// File: rtl/timer_setter_button_edge.sv
// Rising-edge detector: press is high while btn=1 and last cycle's btn=0.
// Ports: clk, reset (sync, active high), btn in, press out.
module button_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) prev <= 1'b0;
        else       prev <= btn;
    end

    assign press = btn & ~prev;
endmodule

// File: rtl/timer_setter.sv
// Egg-timer front end: buttons -> MM:SS preset, edit/run/pause/alarm FSM.
// Ports: clk, reset (sync, active high), bus (timer_setter_if.slave).
module timer_setter
    import timer_pkg::*;
#(
    parameter int ALARM_CYCLES = 100_000_000,
    parameter int MIN_TENS_MAX = 9
) (
    input logic           clk,
    input logic           reset,
    timer_setter_if.slave bus
);
    localparam int CW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ALARM_CYCLES - 1);
    localparam logic [3:0] MIN_TENS_LIM = 4'(MIN_TENS_MAX);

    logic p_up, p_down, p_sel, p_start;
    logic any_press, nonzero;

    state_t        state;
    logic [3:0]    dig [4];
    logic [1:0]    sel_q;
    logic          load_q, str_q, clr_q, alarm_q;
    logic [CW-1:0] acnt;
    logic [3:0]    cur_max;

    button_edge u_up    (.clk(clk), .reset(reset), .btn(bus.btn_up),    .press(p_up));
    button_edge u_down  (.clk(clk), .reset(reset), .btn(bus.btn_down),  .press(p_down));
    button_edge u_sel   (.clk(clk), .reset(reset), .btn(bus.btn_sel),   .press(p_sel));
    button_edge u_start (.clk(clk), .reset(reset), .btn(bus.btn_start), .press(p_start));

    assign any_press = p_up | p_down | p_sel | p_start;
    assign nonzero   = (dig[0] != 4'd0) || (dig[1] != 4'd0) ||
                       (dig[2] != 4'd0) || (dig[3] != 4'd0);

    always_comb begin
        cur_max = SEC_ONES_MAX;
        unique case (sel_q)
            SEL_A1: cur_max = SEC_ONES_MAX;
            SEL_B1: cur_max = SEC_TENS_MAX;
            SEL_C1: cur_max = MIN_ONES_MAX;
            SEL_D1: cur_max = MIN_TENS_LIM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= EDIT;
            for (int i = 0; i < 4; i++) dig[i] <= 4'd0;
            sel_q   <= SEL_A1;
            load_q  <= 1'b1;
            str_q   <= 1'b0;
            clr_q   <= 1'b0;
            alarm_q <= 1'b0;
            acnt    <= '0;
        end else begin
            clr_q <= 1'b0;
            unique case (state)
                EDIT: begin
                    // start outranks everything; an all-zero start is a no-op
                    if (p_start) begin
                        if (nonzero) begin
                            state  <= RUN;
                            load_q <= 1'b0;
                            str_q  <= 1'b1;
                        end
                    end else if (p_sel) begin
                        sel_q <= sel_q + 2'd1;
                    end else if (p_up || p_down) begin
                        dig[sel_q] <= digit_step(dig[sel_q], cur_max, p_up);
                    end
                end
                RUN: begin
                    if (bus.dn) begin
                        state   <= ALARM;
                        str_q   <= 1'b0;
                        alarm_q <= 1'b1;
                        acnt    <= '0;
                    end else if (p_start) begin
                        state <= PAUSE;
                        str_q <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (p_start) begin
                        state <= RUN;
                        str_q <= 1'b1;
                    end else if (p_sel) begin
                        state  <= EDIT;
                        load_q <= 1'b1;
                    end
                end
                ALARM: begin
                    if (any_press || acnt == CNT_LAST) begin
                        state   <= EDIT;
                        alarm_q <= 1'b0;
                        load_q  <= 1'b1;
                        clr_q   <= 1'b1;
                        acnt    <= '0;
                    end else begin
                        acnt <= acnt + 1'b1;
                    end
                end
                default: state <= EDIT;
            endcase
        end
    end

    assign bus.a1    = dig[0];
    assign bus.b1    = dig[1];
    assign bus.c1    = dig[2];
    assign bus.d1    = dig[3];
    assign bus.sel   = sel_q;
    assign bus.load  = load_q;
    assign bus.str   = str_q;
    assign bus.clr   = clr_q;
    assign bus.alarm = alarm_q;
endmodule

// File: tb/tb_timer_setter.sv
// Directed self-checking bench for timer_setter (ALARM_CYCLES = 8).
// Each task drives one scenario and checks its outputs inline.
module tb_timer_setter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    timer_setter_if bus ();

    timer_setter #(.ALARM_CYCLES(8), .MIN_TENS_MAX(9)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0=up 1=down 2=sel 3=start; one-cycle press then one idle cycle
    task automatic press(input int b);
        case (b)
            0: bus.btn_up = 1'b1;
            1: bus.btn_down = 1'b1;
            2: bus.btn_sel = 1'b1;
            default: bus.btn_start = 1'b1;
        endcase
        tick();
        bus.btn_up = 1'b0;
        bus.btn_down = 1'b0;
        bus.btn_sel = 1'b0;
        bus.btn_start = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.a1, bus.b1, bus.c1, bus.d1} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_digits got %h want 0000",
                     {bus.a1, bus.b1, bus.c1, bus.d1});
        end
        checks++;
        if ({bus.sel, bus.load, bus.str, bus.alarm, bus.clr} !== 6'b00_1000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 001000",
                     {bus.sel, bus.load, bus.str, bus.alarm, bus.clr});
        end
    endtask

    task automatic test_wrap();
        do_reset();
        press(1);
        checks++;
        if (bus.a1 !== 4'd9) begin
            errors++;
            $display("FAIL wrap_a1_down got %0d want 9", bus.a1);
        end
        press(2);
        checks++;
        if (bus.sel !== 2'd1) begin
            errors++;
            $display("FAIL sel_adv got %0d want 1", bus.sel);
        end
        for (int i = 0; i < 5; i++) press(0);
        checks++;
        if (bus.b1 !== 4'd5) begin
            errors++;
            $display("FAIL b1_five got %0d want 5", bus.b1);
        end
        press(0);
        checks++;
        if ({bus.b1, bus.c1, bus.d1, bus.a1} !== 16'h0009) begin
            errors++;
            $display("FAIL wrap_b1 got %h want 0009",
                     {bus.b1, bus.c1, bus.d1, bus.a1});
        end
        // held button gives a single step
        press(2);
        press(2);
        bus.btn_down = 1'b1;
        tick();
        tick();
        tick();
        bus.btn_down = 1'b0;
        tick();
        checks++;
        if ({bus.sel, bus.d1} !== {2'd3, 4'd9}) begin
            errors++;
            $display("FAIL held_d1 got sel=%0d d1=%0d want sel=3 d1=9",
                     bus.sel, bus.d1);
        end
        press(0);
        checks++;
        if (bus.d1 !== 4'd0) begin
            errors++;
            $display("FAIL wrap_d1_up got %0d want 0", bus.d1);
        end
        press(2);
        checks++;
        if (bus.sel !== 2'd0) begin
            errors++;
            $display("FAIL sel_wrap got %0d want 0", bus.sel);
        end
    endtask

    task automatic test_start_guard();
        do_reset();
        press(3);
        checks++;
        if ({bus.str, bus.load} !== 2'b01) begin
            errors++;
            $display("FAIL start_guard got str=%b load=%b want str=0 load=1",
                     bus.str, bus.load);
        end
    endtask

    task automatic test_start_done();
        int n;
        do_reset();
        press(0);
        press(0);
        press(0);
        checks++;
        if (bus.a1 !== 4'd3) begin
            errors++;
            $display("FAIL enter_a1 got %0d want 3", bus.a1);
        end
        bus.btn_start = 1'b1;
        tick();
        bus.btn_start = 1'b0;
        checks++;
        if ({bus.str, bus.load} !== 2'b10) begin
            errors++;
            $display("FAIL start_run got str=%b load=%b want str=1 load=0",
                     bus.str, bus.load);
        end
        tick();
        bus.dn = 1'b1;
        tick();
        checks++;
        if ({bus.alarm, bus.str} !== 2'b10) begin
            errors++;
            $display("FAIL done_alarm got alarm=%b str=%b want alarm=1 str=0",
                     bus.alarm, bus.str);
        end
        n = 0;
        while (bus.alarm === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL alarm_len got %0d want 8", n);
        end
        checks++;
        if ({bus.clr, bus.load, bus.a1} !== {2'b11, 4'd3}) begin
            errors++;
            $display("FAIL alarm_exit got clr=%b load=%b a1=%0d want 1 1 3",
                     bus.clr, bus.load, bus.a1);
        end
        bus.dn = 1'b0;
        tick();
        checks++;
        if (bus.clr !== 1'b0) begin
            errors++;
            $display("FAIL clr_pulse got %b want 0", bus.clr);
        end
        // second run: up press on alarm cycle 3 cuts it short
        press(3);
        bus.dn = 1'b1;
        tick();
        tick();
        tick();
        bus.btn_up = 1'b1;
        tick();
        bus.btn_up = 1'b0;
        checks++;
        if ({bus.alarm, bus.clr, bus.load, bus.a1} !== {3'b011, 4'd3}) begin
            errors++;
            $display("FAIL alarm_press got alarm=%b clr=%b load=%b a1=%0d want 0 1 1 3",
                     bus.alarm, bus.clr, bus.load, bus.a1);
        end
        bus.dn = 1'b0;
        tick();
        checks++;
        if ({bus.clr, bus.a1} !== {1'b0, 4'd3}) begin
            errors++;
            $display("FAIL alarm_after got clr=%b a1=%0d want 0 3",
                     bus.clr, bus.a1);
        end
    endtask

    task automatic test_pause();
        do_reset();
        press(2);
        press(0);
        press(0);
        press(0);
        press(2);
        press(0);
        press(3);
        press(0);
        checks++;
        if ({bus.str, bus.load, bus.c1} !== {2'b10, 4'd1}) begin
            errors++;
            $display("FAIL run_ignore got str=%b load=%b c1=%0d want 1 0 1",
                     bus.str, bus.load, bus.c1);
        end
        press(3);
        checks++;
        if ({bus.str, bus.load} !== 2'b00) begin
            errors++;
            $display("FAIL pause got str=%b load=%b want 0 0", bus.str, bus.load);
        end
        press(2);
        checks++;
        if ({bus.load, bus.str} !== 2'b10) begin
            errors++;
            $display("FAIL cancel got load=%b str=%b want 1 0", bus.load, bus.str);
        end
        checks++;
        if ({bus.a1, bus.b1, bus.c1, bus.d1} !== 16'h0310) begin
            errors++;
            $display("FAIL preset_kept got %h want 0310",
                     {bus.a1, bus.b1, bus.c1, bus.d1});
        end
    endtask

    task automatic test_priority_reset();
        do_reset();
        press(0);
        bus.btn_start = 1'b1;
        bus.btn_sel = 1'b1;
        tick();
        bus.btn_start = 1'b0;
        bus.btn_sel = 1'b0;
        checks++;
        if ({bus.str, bus.sel} !== {1'b1, 2'd0}) begin
            errors++;
            $display("FAIL prio got str=%b sel=%0d want 1 0", bus.str, bus.sel);
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({bus.str, bus.load, bus.clr, bus.a1} !== {3'b010, 4'd0}) begin
            errors++;
            $display("FAIL run_reset got str=%b load=%b clr=%b a1=%0d want 0 1 0 0",
                     bus.str, bus.load, bus.clr, bus.a1);
        end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        bus.btn_up = 1'b0;
        bus.btn_down = 1'b0;
        bus.btn_sel = 1'b0;
        bus.btn_start = 1'b0;
        bus.dn = 1'b0;
        test_reset();
        test_wrap();
        test_start_guard();
        test_start_done();
        test_pause();
        test_priority_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
